// File: rtl/output_writeback.sv
// Output writeback: buffers top_system results in a small FIFO and writes them to external memory.
// Optional define OUTPUT_WRITEBACK_CHECKSUM_EN adds a rotate-XOR checksum of completed writes.
module output_writeback #(
    parameter int ACCUMULATION_WIDTH = 32,
    parameter int EXT_MEM_HEIGHT     = 1 << 20,
    parameter int FEATURE_MAP_WIDTH  = 128,
    parameter int FEATURE_MAP_HEIGHT = 128,
    parameter int OUTPUT_NB_CHANNELS = 16,
    parameter int FIFO_DEPTH         = 4,
    parameter int BASE_ADDR          = 0,
    localparam int ADDR_W = $clog2(EXT_MEM_HEIGHT),
    localparam int X_W    = $clog2(FEATURE_MAP_WIDTH),
    localparam int Y_W    = $clog2(FEATURE_MAP_HEIGHT),
    localparam int CH_W   = $clog2(OUTPUT_NB_CHANNELS),
    localparam int TOTAL  = FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS,
    localparam int CNT_W  = $clog2(TOTAL + 1)
) (
    input  logic                          clk,
    input  logic                          arst,
    input  logic                          start,
    input  logic [ACCUMULATION_WIDTH-1:0] out,
    input  logic                          output_valid,
    input  logic [X_W-1:0]                output_x,
    input  logic [Y_W-1:0]                output_y,
    input  logic [CH_W-1:0]               output_ch,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [ACCUMULATION_WIDTH-1:0] mem_wdata,
    output logic                          mem_valid,
    input  logic                          mem_ready,
    output logic                          busy,
    output logic                          done,
    output logic                          overflow,
    output logic [CNT_W-1:0]              beat_count
`ifdef OUTPUT_WRITEBACK_CHECKSUM_EN
    ,
    output logic [ACCUMULATION_WIDTH-1:0] checksum
`endif
);

    localparam int IDX_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

    state_t state, state_next;

    logic [PTR_W-1:0]              wr_ptr, rd_ptr;
    logic [ADDR_W-1:0]             addr_mem [FIFO_DEPTH];
    logic [ACCUMULATION_WIDTH-1:0] data_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]             addr_calc;
    logic                          empty, full, pop, push, drop, beat_in, last_beat, start_accept;

    // Channel-major linear address; the cast truncates modulo 2^ADDR_W.
    assign addr_calc = ADDR_W'(BASE_ADDR
                     + (int'(output_ch) * FEATURE_MAP_HEIGHT + int'(output_y)) * FEATURE_MAP_WIDTH
                     + int'(output_x));

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                   (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);

    assign beat_in      = (state == COLLECT) && output_valid;
    assign pop          = !empty && mem_ready;
    assign push         = beat_in && (!full || pop);
    assign drop         = beat_in && !push;
    assign last_beat    = beat_in && (beat_count == CNT_W'(TOTAL - 1));
    assign start_accept = start && ((state == IDLE) || (state == DONE));

    assign mem_valid = !empty;
    assign mem_addr  = addr_mem[rd_ptr[IDX_W-1:0]];
    assign mem_wdata = data_mem[rd_ptr[IDX_W-1:0]];
    assign busy      = (state == COLLECT) || (state == DRAIN);
    assign done      = (state == DONE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) state <= IDLE;
        else      state <= state_next;
    end

    // NOTE: the default assignment first keeps this block purely combinational (no latch).
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = COLLECT;
            COLLECT: if (last_beat) state_next = DRAIN;
            DRAIN:   if (empty) state_next = DONE;
            DONE:    if (start) state_next = COLLECT;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // NOTE: storage is reset (it is tiny) so the head outputs read 0 straight out of reset.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                addr_mem[i] <= '0;
                data_mem[i] <= '0;
            end
        end else if (push) begin
            addr_mem[wr_ptr[IDX_W-1:0]] <= addr_calc;
            data_mem[wr_ptr[IDX_W-1:0]] <= out;
        end
    end

    // Dropped beats still count so a tensor always completes.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            beat_count <= '0;
            overflow   <= 1'b0;
        end else if (start_accept) begin
            beat_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (beat_in) beat_count <= beat_count + CNT_W'(1);
            if (drop)    overflow   <= 1'b1;
        end
    end

`ifdef OUTPUT_WRITEBACK_CHECKSUM_EN
    always_ff @(posedge clk or posedge arst) begin
        if (arst)              checksum <= '0;
        else if (start_accept) checksum <= '0;
        else if (pop)          checksum <= {checksum[ACCUMULATION_WIDTH-2:0],
                                            checksum[ACCUMULATION_WIDTH-1]} ^ mem_wdata;
    end
`endif

endmodule

// File: tb/tb_output_writeback.sv
// Self-checking bench for output_writeback: directed table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_output_writeback;

    localparam int AW     = 32;
    localparam int EMH    = 4096;
    localparam int FW     = 4;
    localparam int FH     = 2;
    localparam int NCH    = 2;
    localparam int DEPTH  = 4;
    localparam int BASE   = 'h100;
    localparam int TOTAL  = FW * FH * NCH;

    logic          clk = 1'b0;
    logic          arst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] out = '0;
    logic          output_valid = 1'b0;
    logic [1:0]    output_x = '0;
    logic [0:0]    output_y = '0;
    logic [0:0]    output_ch = '0;
    logic [11:0]   mem_addr;
    logic [AW-1:0] mem_wdata;
    logic          mem_valid;
    logic          mem_ready = 1'b0;
    logic          busy, done, overflow;
    logic [4:0]    beat_count;
`ifdef OUTPUT_WRITEBACK_CHECKSUM_EN
    logic [AW-1:0] checksum;
`endif

    output_writeback #(
        .ACCUMULATION_WIDTH(AW), .EXT_MEM_HEIGHT(EMH), .FEATURE_MAP_WIDTH(FW),
        .FEATURE_MAP_HEIGHT(FH), .OUTPUT_NB_CHANNELS(NCH), .FIFO_DEPTH(DEPTH),
        .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .arst(arst), .start(start), .out(out), .output_valid(output_valid),
        .output_x(output_x), .output_y(output_y), .output_ch(output_ch),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_valid(mem_valid),
        .mem_ready(mem_ready), .busy(busy), .done(done), .overflow(overflow),
        .beat_count(beat_count)
`ifdef OUTPUT_WRITEBACK_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int          x;
        int          y;
        int          ch;
        logic [11:0] addr;
    } vec_t;

    // Reference model: pending writes in arrival order plus tensor progress.
    wr_t         mq[$];
    bit          m_run, m_done, m_ovf;
    int          m_count;
    logic [31:0] m_ck;

    int tests = 0;
    int failed = 0;
    int wr_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] ref_addr(input int x, input int y, input int ch);
        return 12'((BASE + (ch * FH + y) * FW + x) % EMH);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_run = 0; m_done = 0; m_ovf = 0; m_count = 0; m_ck = '0;
    endtask

    // Effect of one clock edge, computed from the values in force before it.
    task automatic model_edge(input bit v, input int x, input int y, input int ch,
                              input logic [31:0] d, input bit rdy, input bit st);
        int  pre        = mq.size();
        bit  pop        = (pre > 0) && rdy;
        bit  collecting = m_run && !m_done && (m_count < TOTAL);
        bit  draining   = m_run && !m_done && (m_count == TOTAL);
        bit  armable    = !m_run || m_done;
        wr_t e;
        if (pop) begin
            e = mq.pop_front();
            m_ck = {m_ck[30:0], m_ck[31]} ^ e.data;
        end
        if (collecting && v) begin
            m_count++;
            if (pre < DEPTH || pop) mq.push_back('{ref_addr(x, y, ch), d});
            else                    m_ovf = 1;
        end
        if (draining && pre == 0) m_done = 1;
        if (armable && st) begin
            m_run = 1; m_done = 0; m_count = 0; m_ovf = 0; m_ck = '0;
        end
    endtask

    task automatic compare_all();
        check("mem_valid", mem_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            check("mem_addr", mem_addr, mq[0].addr);
            check("mem_wdata", mem_wdata, mq[0].data);
        end
        check("busy", busy, m_run && !m_done);
        check("done", done, m_done);
        check("overflow", overflow, m_ovf);
        check("beat_count", beat_count, m_count);
`ifdef OUTPUT_WRITEBACK_CHECKSUM_EN
        check("checksum", checksum, m_ck);
`endif
    endtask

    // Called at a negedge: drive inputs, advance the model, cross one posedge, compare.
    task automatic step(input bit v, input int x, input int y, input int ch,
                        input logic [31:0] d, input bit rdy, input bit st);
        output_valid = v;
        output_x     = 2'(x);
        output_y     = 1'(y);
        output_ch    = 1'(ch);
        out          = d;
        mem_ready    = rdy;
        start        = st;
        if (mem_valid && rdy) wr_cnt++;
        model_edge(v, x, y, ch, d, rdy, st);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic beat(input int i, input logic [31:0] d, input bit rdy);
        step(1'b1, i % FW, (i / FW) % FH, i / (FW * FH), d, rdy, 1'b0);
    endtask

    task automatic idle(input bit rdy, input bit st);
        step(1'b0, 0, 0, 0, '0, rdy, st);
    endtask

    task automatic drain_until_done(input int bound);
        for (int n = 0; n < bound && !done; n++) idle(1'b1, 1'b0);
        check("drain_done", done, 1'b1);
    endtask

    task automatic do_reset();
        output_valid = 1'b0;
        start        = 1'b0;
        mem_ready    = 1'b0;
        arst         = 1'b1;
        #1;
        check("rst_mem_valid", mem_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_beat_count", beat_count, 5'd0);
        check("rst_mem_addr", mem_addr, 12'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        arst = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[16];
        tbl = '{'{0,0,0,'h100}, '{3,1,1,'h10F}, '{1,0,0,'h101}, '{2,1,0,'h106},
                '{3,0,1,'h10B}, '{0,1,1,'h10C}, '{2,0,0,'h102}, '{1,1,1,'h10D},
                '{3,1,0,'h107}, '{0,0,1,'h108}, '{1,1,0,'h105}, '{2,0,1,'h10A},
                '{3,0,0,'h103}, '{2,1,1,'h10E}, '{0,1,0,'h104}, '{1,0,1,'h109}};

        @(negedge clk);
        do_reset();
        idle(1'b1, 1'b0);

        // Back-to-back tensor with mem_ready high; each beat is the head one cycle later.
        idle(1'b1, 1'b1);
        for (int k = 0; k < 16; k++) begin
            step(1'b1, tbl[k].x, tbl[k].y, tbl[k].ch, 32'(k), 1'b1, 1'b0);
            check($sformatf("tbl_valid_%0d", k), mem_valid, 1'b1);
            check($sformatf("tbl_addr_%0d", k), mem_addr, tbl[k].addr);
            check($sformatf("tbl_data_%0d", k), mem_wdata, 32'(k));
        end
        check("t1_done_n0", done, 1'b0);
        idle(1'b1, 1'b0);
        check("t1_done_n1", done, 1'b0);
        idle(1'b1, 1'b0);
        check("t1_done_n2", done, 1'b1);
        check("t1_overflow", overflow, 1'b0);
        check("t1_beat_count", beat_count, 5'd16);

        // Back-pressure: four beats buffered, two dropped, fourteen writes in total.
        idle(1'b0, 1'b1);
        wr_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            beat(i, 32'(i), 1'b0);
            if (i == 3) check("t2_ovf_before_drop", overflow, 1'b0);
            if (i == 4) check("t2_ovf_after_drop", overflow, 1'b1);
        end
        check("t2_beat_count6", beat_count, 5'd6);
        check("t2_head_addr", mem_addr, 12'h100);
        for (int i = 6; i < 16; i++) beat(i, 32'(i), 1'b1);
        drain_until_done(20);
        check("t2_writes", wr_cnt, 14);
        check("t2_beat_count16", beat_count, 5'd16);
        check("t2_overflow", overflow, 1'b1);

        // Stall holds the head; then full FIFO with simultaneous push and pop.
        idle(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            beat(i, 32'hA0 + 32'(i), 1'b0);
            check("t3_stall_addr", mem_addr, 12'h100);
            check("t3_stall_data", mem_wdata, 32'hA0);
        end
        wr_cnt = 0;
        beat(4, 32'hA4, 1'b1);
        check("t3_full_pushpop_ovf", overflow, 1'b0);
        check("t3_head_after_pop", mem_addr, 12'h101);
        for (int n = 0; n < 10 && mem_valid; n++) idle(1'b1, 1'b0);
        check("t3_writes_occupancy", wr_cnt, 5);
        for (int i = 5; i < 16; i++) beat(i, 32'(i), 1'b1);
        drain_until_done(20);

        // Reset mid-transfer with three entries queued.
        idle(1'b0, 1'b1);
        beat(0, 32'h0, 1'b0);
        beat(1, 32'h1, 1'b1);
        beat(2, 32'h2, 1'b1);
        beat(3, 32'h3, 1'b0);
        beat(4, 32'h4, 1'b0);
        check("t5_queued_head", mem_addr, 12'h102);
        do_reset();
        wr_cnt = 0;
        for (int i = 5; i < 9; i++) beat(i, 32'(i), 1'b1);
        check("t5_no_writes", wr_cnt, 0);
        check("t5_idle_busy", busy, 1'b0);
        check("t5_idle_count", beat_count, 5'd0);

`ifdef OUTPUT_WRITEBACK_CHECKSUM_EN
        idle(1'b1, 1'b1);
        beat(0, 32'h1, 1'b1);
        beat(1, 32'h2, 1'b1);
        check("ck_after_1", checksum, 32'h1);
        beat(2, 32'h4, 1'b1);
        check("ck_after_2", checksum, 32'h0);
        beat(3, 32'h0, 1'b1);
        check("ck_after_4", checksum, 32'h4);
        for (int i = 4; i < 16; i++) beat(i, 32'h0, 1'b1);
        drain_until_done(20);
        idle(1'b1, 1'b1);
        check("ck_cleared", checksum, 32'h0);
        for (int i = 0; i < 16; i++) beat(i, 32'h0, 1'b1);
        drain_until_done(20);
`endif

        // Randomized tensors with varied back-pressure, stray starts and random coordinates.
        for (int t = 0; t < 6; t++) begin
            int pct = (t % 2 == 0) ? 80 : 30;
            idle(1'b1, 1'b1);
            for (int n = 0; n < 600 && !m_done; n++) begin
                step($urandom_range(0, 9) < 7,
                     int'($urandom_range(0, FW - 1)), int'($urandom_range(0, FH - 1)),
                     int'($urandom_range(0, NCH - 1)), $urandom,
                     $urandom_range(0, 99) < pct, $urandom_range(0, 19) == 0);
            end
            check($sformatf("rand_done_%0d", t), done, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
